// File: rtl/mul32_shift_add.sv
// mul32_shift_add: iterative 32x32->64 shift-and-add multiplier.
// One operation in flight, with valid/ready on both the operand and product sides.
// Each BUSY cycle adds the multiplicand (or zero) into the high word.
// The 33-bit {cout,out} sum is then shifted right one bit across {acc_hi,acc_lo}.
// Optional feature: define MUL32_SIGNED_EN for two's-complement operands.
// The signed build adds a FIX state that negates the product.
module mul32_shift_add #(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_prod
);

  if (XLEN != 32) begin : g_bad_xlen
    $error("mul32_shift_add: XLEN must be 32 (fixed by Adder32)");
  end

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_BUSY = 2'b01;
  localparam logic [1:0] S_FIX  = 2'b10;
  localparam logic [1:0] S_DONE = 2'b11;

  logic [1:0]  state;
  logic [31:0] mcand;
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;   // multiplier bits shift out the bottom while product bits shift in
  logic [4:0]  count;

  // Adder32 stage: cin=0, in1=acc_hi, in2 gated by the current multiplier bit.
  logic [31:0] add_in2;
  logic [32:0] add_sum;  // {cout,out}
  assign add_in2 = acc_lo[0] ? mcand : 32'd0;
  assign add_sum = {1'b0, acc_hi} + {1'b0, add_in2};

  // While reset is asserted, in_ready reads 0 even though the state register holds IDLE.
  assign in_ready  = rst_n & (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign out_prod  = out_valid ? {acc_hi, acc_lo} : 64'd0;

`ifdef MUL32_SIGNED_EN
  logic        neg;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [63:0] neg_prod;
  // Magnitudes: 0x80000000 negates to itself, which is 2^31 read as unsigned.
  assign mag_a    = in_a[31] ? (~in_a + 32'd1) : in_a;
  assign mag_b    = in_b[31] ? (~in_b + 32'd1) : in_b;
  assign neg_prod = ~{acc_hi, acc_lo} + 64'd1;
`endif

  // Control FSM and datapath: accept, iterate 32 times, optionally fix sign, then hold the product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      count  <= '0;
`ifdef MUL32_SIGNED_EN
      neg    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
`ifdef MUL32_SIGNED_EN
            mcand  <= mag_a;
            acc_lo <= mag_b;
            neg    <= in_a[31] ^ in_b[31];
`else
            mcand  <= in_a;
            acc_lo <= in_b;
`endif
            acc_hi <= '0;
            count  <= '0;
            state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          acc_hi <= add_sum[32:1];
          acc_lo <= {add_sum[0], acc_lo[31:1]};
          count  <= count + 5'd1;
          if (count == 5'd31) begin
`ifdef MUL32_SIGNED_EN
            state <= S_FIX;
`else
            state <= S_DONE;
`endif
          end
        end
`ifdef MUL32_SIGNED_EN
        S_FIX: begin
          if (neg) {acc_hi, acc_lo} <= neg_prod;
          state <= S_DONE;
        end
`endif
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul32_shift_add.sv
// Directed + random bench for mul32_shift_add.
// The reference product comes from plain 64-bit arithmetic.
// Define MUL32_SIGNED_EN to exercise the signed build.
module tb_mul32_shift_add;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_prod;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef MUL32_SIGNED_EN
  localparam int LAT = 33;
`else
  localparam int LAT = 32;
`endif

  mul32_shift_add dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
`ifdef MUL32_SIGNED_EN
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
`else
    return {32'd0, a} * {32'd0, b};
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Present operands for one accept edge; afterwards drop in_valid and scramble the operands.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input string tag);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    chk({tag, " ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_a = a; in_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
    chk({tag, " busy"}, 64'(in_ready), 64'd0);
  endtask

  // Count edges from the accept edge to out_valid, then check latency and product.
  task automatic wait_done(input logic [31:0] a, input logic [31:0] b, input string tag);
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (!out_valid && n < 200);
    chk({tag, " latency"}, 64'(n), 64'(LAT));
    chk({tag, " prod"}, out_prod, ref_mul(a, b));
  endtask

  task automatic deliver(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " vld drop"}, 64'(out_valid), 64'd0);
    chk({tag, " idle rdy"}, 64'(in_ready), 64'd1);
  endtask

  task automatic full_op(input logic [31:0] a, input logic [31:0] b, input string tag);
    start_op(a, b, tag);
    wait_done(a, b, tag);
    deliver(tag);
  endtask

  initial begin
    logic [63:0] held;
    logic [31:0] ra, rb, a2, b2;
    int n;

    // 1: reset state, then 3 x 5.
    #2;
    chk("rst in_ready", 64'(in_ready), 64'd0);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst out_prod", out_prod, 64'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("post rst in_ready", 64'(in_ready), 64'd1);
    full_op(32'd3, 32'd5, "3x5");
    chk("3x5 const", ref_mul(32'd3, 32'd5), 64'd15);

    // 2: all-ones operands exercise the carry into acc_hi[31].
`ifndef MUL32_SIGNED_EN
    full_op(32'hFFFFFFFF, 32'hFFFFFFFF, "ffxff");
    full_op(32'h80000000, 32'h80000000, "8x8u");
`endif

    // 3: product held while out_ready stays low; new operands are ignored.
    ra = 32'h1234_5678; rb = 32'h9ABC_DEF0;
    start_op(ra, rb, "hold");
    wait_done(ra, rb, "hold");
    held = out_prod;
    in_valid = 1'b1; in_a = 32'd11; in_b = 32'd13;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold vld", 64'(out_valid), 64'd1);
      chk("hold prod", out_prod, held);
      chk("hold rdy", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    deliver("hold");

    // 4: asynchronous reset mid-iteration discards the op.
    start_op(32'hDEAD_BEEF, 32'h0BAD_F00D, "abort");
    repeat (15) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    chk("abort vld", 64'(out_valid), 64'd0);
    chk("abort prod", out_prod, 64'd0);
    chk("abort rdy", 64'(in_ready), 64'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("abort idle", 64'(in_ready), 64'd1);
    full_op(32'd7, 32'd6, "7x6");

    // 5: signed corner cases.
`ifdef MUL32_SIGNED_EN
    full_op(32'hFFFFFFFD, 32'd5, "m3x5");
    chk("m3x5 const", ref_mul(32'hFFFFFFFD, 32'd5), 64'hFFFFFFFF_FFFFFFF1);
    full_op(32'h80000000, 32'h80000000, "8x8s");
    full_op(32'h80000000, 32'd1, "8x1s");
    full_op(32'hFFFFFFFF, 32'hFFFFFFFF, "m1xm1");
`endif

    // 6: back-to-back with in_valid and out_ready held high.
    ra = $urandom; rb = $urandom; a2 = $urandom; b2 = $urandom;
    @(negedge clk);
    chk("b2b ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_a = ra; in_b = rb; out_ready = 1'b1;
    @(posedge clk); #1;
    in_a = a2; in_b = b2;
    wait_done(ra, rb, "b2b1");
    @(posedge clk); #1;
    chk("b2b gap vld", 64'(out_valid), 64'd0);
    chk("b2b gap rdy", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    chk("b2b acc2", 64'(in_ready), 64'd0);
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
    wait_done(a2, b2, "b2b2");
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("b2b end vld", 64'(out_valid), 64'd0);

    // Random operands against the arithmetic reference.
    n = 0;
    repeat (10) begin
      ra = $urandom; rb = $urandom;
      if (n == 0) rb = 32'd0;
      if (n == 1) ra = 32'd1;
      full_op(ra, rb, "rand");
      n++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
